index_buffer_drain: RTL and testbench
=====================================

// Module: index_buffer_drain
// PURPOSE
//  Read-side counterpart of the per-group index buffer allocator. For one group it walks
//  the buffer blocks that group owns, in ascending block order (= allocation order).
//  It emits one entry address per handshake and releases each block after its last entry.
//  Sits between the group scheduler (request side) and the index buffer SRAM read port.
// PARAMETERS
//  NUM_BLOCKS  256  buffer blocks; ownership bitmap width
//  BLK_W       8    block address width, = clog2(NUM_BLOCKS)
//  CNT_W       8    entry offset width; a block holds 2**CNT_W entries
//  GRP_W       8    group index width
// PORTS
//  clk             in   1             clock, all logic rising-edge
//  rst             in   1             synchronous reset, active-high
//  req_valid       in   1             drain request valid
//  req_ready       out  1             high only in IDLE
//  req_grp         in   GRP_W         group to drain, echoed on done_grp
//  req_map         in   NUM_BLOCKS    bit b set = block b owned by group
//  req_tail_cnt    in   CNT_W         entries in highest owned block; 0 = full block
//  rd_valid        out  1             entry address valid
//  rd_ready        in   1             SRAM read port accepts address
//  rd_addr         out  BLK_W+CNT_W   {block, offset}
//  rd_last         out  1             final entry of the whole group
//  free_valid      out  1             1-cycle pulse: block released
//  free_blk        out  BLK_W         released block address
//  done            out  1             1-cycle pulse: drain complete
//  done_grp        out  GRP_W         group of completed drain
// BEHAVIOUR
//  Reset: state=IDLE; rd_valid, free_valid and done are 0; rd_addr, free_blk and done_grp
//   are 0; internal map, offset and block registers are cleared.
//  FSM states: IDLE, SCAN, EMIT, DONE.
//  IDLE
//   - req_valid & req_ready latches grp, map and tail_cnt, then goes to SCAN.
//  SCAN
//   - map==0: go to DONE. An all-zero request therefore yields no reads.
//   - else: blk <= lowest set bit (combinational priority encoder); clear that bit in map;
//     off <= 0; last_blk <= (map with that bit cleared)==0; go to EMIT.
//  EMIT
//   - rd_valid=1, rd_addr={blk,off}.
//   - lim = (last_blk && tail_cnt!=0) ? tail_cnt : 2**CNT_W.
//   - rd_last = last_blk && (off==lim-1).
//   - On rd_valid&rd_ready: if off==lim-1 then free_valid=1 and free_blk=blk next cycle,
//     and state -> SCAN (or DONE if last_blk); else off++.
//   - rd_addr and rd_last hold stable while rd_valid & !rd_ready.
//   - Offset arithmetic is done CNT_W+1 wide so that a full block (lim=2**CNT_W) ends at
//     off=2**CNT_W-1 without wrap.
//  DONE
//   - done=1 and done_grp=grp for one cycle, then IDLE.
//   - req_ready is 0 here, so back-to-back drains cost 1 idle cycle.
//  Latency: request accept -> first rd_valid is 2 cycles (SCAN in between). Each block
//   costs 1 SCAN cycle plus one cycle per entry at full rd_ready.
//  free_valid for the final block coincides with the cycle done is asserted.
//  rst mid-drain: abandon immediately, return to reset values; no free or done pulse.
//  req_valid outside IDLE is ignored; upstream must hold it until accepted.
// CONFIGURATION
//  IBD_ABORT_EN defined: adds input abort (1b) and output done_abort (1b).
//   - abort sampled in SCAN/EMIT (an EMIT handshake in the same cycle is still
//     completed) -> DONE.
//   - The current block is freed only if its last entry was handshaken; untouched blocks
//     are not freed.
//   - done_abort=1 together with done.
//  IBD_ABORT_EN undefined: no abort port, no done_abort port; drains always run to
//   completion.
// TESTING
//  T1 reset: rst=1 for 3 cycles mid-EMIT -> rd_valid, free_valid and done are 0;
//     req_ready=1 the cycle after release.
//  T2 single block: map=bit5, tail_cnt=3, rd_ready=1 -> rd_addr 0x0500, 0x0501, 0x0502
//     (rd_last on 0x0502); free_blk=5; done, done_grp=req_grp.
//  T3 multi block: map={bit9,bit2}, tail_cnt=0 -> 256 addrs 0x0200..0x02FF, free 2;
//     then 0x0900..0x09FF, rd_last at 0x09FF, free 9, done.
//  T4 empty: map=0 -> no rd_valid; done 2 cycles after accept.
//  T5 backpressure: random rd_ready on T3 -> rd_addr stable while stalled; same address
//     sequence and free order as T3.
//  T6 (IBD_ABORT_EN) abort at 0x0210 in T3 -> 0x0210 accepted if ready; no free; done and
//     done_abort=1.

Source files
------------

// File: rtl/index_buffer_drain_if.sv
// index_buffer_drain_if: request, SRAM-read, free and completion signals of the
// index buffer drain engine. With IBD_ABORT_EN defined the bundle also carries
// abort (into the drain engine) and done_abort (out of it).
interface index_buffer_drain_if #(
  parameter int NUM_BLOCKS = 256,
  parameter int BLK_W      = 8,
  parameter int CNT_W      = 8,
  parameter int GRP_W      = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [GRP_W-1:0]       req_grp;
  logic [NUM_BLOCKS-1:0]  req_map;
  logic [CNT_W-1:0]       req_tail_cnt;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [BLK_W+CNT_W-1:0] rd_addr;
  logic                   rd_last;
  logic                   free_valid;
  logic [BLK_W-1:0]       free_blk;
  logic                   done;
  logic [GRP_W-1:0]       done_grp;
`ifdef IBD_ABORT_EN
  logic                   abort;
  logic                   done_abort;

  // Scheduler / SRAM side.
  modport master (
    output req_valid, req_grp, req_map, req_tail_cnt, rd_ready, abort,
    input  req_ready, rd_valid, rd_addr, rd_last, free_valid, free_blk,
           done, done_grp, done_abort
  );

  // Drain engine side.
  modport slave (
    input  req_valid, req_grp, req_map, req_tail_cnt, rd_ready, abort,
    output req_ready, rd_valid, rd_addr, rd_last, free_valid, free_blk,
           done, done_grp, done_abort
  );
`else
  // Scheduler / SRAM side.
  modport master (
    output req_valid, req_grp, req_map, req_tail_cnt, rd_ready,
    input  req_ready, rd_valid, rd_addr, rd_last, free_valid, free_blk,
           done, done_grp
  );

  // Drain engine side.
  modport slave (
    input  req_valid, req_grp, req_map, req_tail_cnt, rd_ready,
    output req_ready, rd_valid, rd_addr, rd_last, free_valid, free_blk,
           done, done_grp
  );
`endif
endinterface

// File: rtl/index_buffer_drain.sv
// index_buffer_drain: walks the blocks owned by one group in ascending order,
// emits one {block, offset} read address per handshake, pulses a free for each
// block after its last entry and pulses done at the end of the drain.
// Optional feature macro: IBD_ABORT_EN (abort input, done_abort output).
module index_buffer_drain #(
  parameter int NUM_BLOCKS = 256,
  parameter int BLK_W      = 8,
  parameter int CNT_W      = 8,
  parameter int GRP_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  index_buffer_drain_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  // Entry limit of a full block; one bit wider than the offset so it does not wrap.
  localparam logic [CNT_W:0] FULL_LIM = {1'b1, {CNT_W{1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic [GRP_W-1:0]      r_grp;
  logic [NUM_BLOCKS-1:0] r_map;
  logic [CNT_W-1:0]      r_tail;
  logic [BLK_W-1:0]      r_blk;
  logic [CNT_W:0]        r_off;
  logic                  r_last_blk;
  logic                  r_free_valid;
  logic [BLK_W-1:0]      r_free_blk;

  logic [BLK_W-1:0]      w_low_blk;
  logic [NUM_BLOCKS-1:0] w_map_rest;
  logic [CNT_W:0]        w_lim;
  logic                  w_blk_end;
  logic                  w_fire;
  logic                  w_abort;
  logic                  w_req_ready;
  logic                  w_rd_valid;
  logic                  w_done;

  // Priority encoder: index of the lowest owned block still in the map.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_low_blk = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (r_map[i]) w_low_blk = BLK_W'(i);
    end
  end

  // Map with its lowest set bit removed (x & (x-1)).
  assign w_map_rest = r_map & (r_map - NUM_BLOCKS'(1));
  assign w_lim      = (r_last_blk && r_tail != '0) ? {1'b0, r_tail} : FULL_LIM;
  assign w_blk_end  = (r_off == w_lim - (CNT_W + 1)'(1));
  assign w_fire     = (r_state == S_EMIT) && bus.rd_ready;

`ifdef IBD_ABORT_EN
  logic r_aborted;

  assign w_abort = bus.abort && (r_state == S_SCAN || r_state == S_EMIT);

  // Remember that the current drain was cut short, reported alongside done.
  always_ff @(posedge clk) begin
    if (rst)                    r_aborted <= 1'b0;
    else if (r_state == S_IDLE) r_aborted <= 1'b0;
    else if (w_abort)           r_aborted <= 1'b1;
  end

  assign bus.done_abort = (r_state == S_DONE) && r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rd_valid  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_abort || r_map == '0) w_next = S_DONE;
        else                        w_next = S_EMIT;
      end
      S_EMIT: begin
        w_rd_valid = 1'b1;
        if (w_abort)                  w_next = S_DONE;
        else if (w_fire && w_blk_end) w_next = r_last_blk ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, block selection, offset walk and free pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the ownership map is a flop vector, not an SRAM, so it is cleared on reset.
      r_grp        <= '0;
      r_map        <= '0;
      r_tail       <= '0;
      r_blk        <= '0;
      r_off        <= '0;
      r_last_blk   <= 1'b0;
      r_free_valid <= 1'b0;
      r_free_blk   <= '0;
    end else begin
      r_free_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_grp  <= bus.req_grp;
            r_map  <= bus.req_map;
            r_tail <= bus.req_tail_cnt;
          end
        end
        S_SCAN: begin
          if (!w_abort && r_map != '0) begin
            r_blk      <= w_low_blk;
            r_map      <= w_map_rest;
            r_off      <= '0;
            r_last_blk <= (w_map_rest == '0);
          end
        end
        S_EMIT: begin
          if (w_fire) begin
            if (w_blk_end) begin
              r_free_valid <= 1'b1;
              r_free_blk   <= r_blk;
            end else begin
              r_off <= r_off + (CNT_W + 1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rd_valid   = w_rd_valid;
  assign bus.rd_addr    = {r_blk, r_off[CNT_W-1:0]};
  assign bus.rd_last    = w_rd_valid && r_last_blk && w_blk_end;
  assign bus.free_valid = r_free_valid;
  assign bus.free_blk   = r_free_blk;
  assign bus.done       = w_done;
  assign bus.done_grp   = w_done ? r_grp : '0;

endmodule

// File: tb/tb_index_buffer_drain.sv
// tb_index_buffer_drain: directed and randomized drains of index_buffer_drain
// checked against a list-based reference model of the expected reads and frees.
// Abort scenarios are included when IBD_ABORT_EN is defined.
module tb_index_buffer_drain;
  localparam int NB = 256;
  localparam int BW = 8;
  localparam int CW = 8;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  index_buffer_drain_if #(.NUM_BLOCKS(NB), .BLK_W(BW), .CNT_W(CW), .GRP_W(GW)) bus ();

  index_buffer_drain #(.NUM_BLOCKS(NB), .BLK_W(BW), .CNT_W(CW), .GRP_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model output: expected read stream and free order.
  logic [15:0] exp_addr[$];
  bit          exp_last[$];
  logic [7:0]  exp_free[$];
  int          exp_free_end[$];  // reads that must be accepted before this free is due

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s", tag);
  endtask

  // Every owned block in ascending order; the highest one holds tail entries
  // (0 meaning a full block of 256), every other block is full.
  function automatic void build_model(logic [255:0] map, logic [7:0] tail);
    int hi = -1;
    exp_addr.delete();
    exp_last.delete();
    exp_free.delete();
    exp_free_end.delete();
    for (int b = 0; b < NB; b++) if (map[b]) hi = b;
    for (int b = 0; b < NB; b++) begin
      if (map[b]) begin
        int n = (b == hi && tail != 0) ? int'(tail) : 256;
        for (int o = 0; o < n; o++) begin
          exp_addr.push_back({8'(b), 8'(o)});
          exp_last.push_back(b == hi && o == n - 1);
        end
        exp_free.push_back(8'(b));
        exp_free_end.push_back(exp_addr.size());
      end
    end
  endfunction

  task automatic drain(input string name, input logic [7:0] grp, input logic [255:0] map,
                       input logic [7:0] tail, input bit rnd, input int abort_addr);
    int n_addr = 0;
    int n_free = 0;
    int exp_cnt;
    int exp_nfree;
    int first_valid = -1;
    int done_cyc = -1;
    bit stalled = 1'b0;
    bit aborted = 1'b0;
    bit seen_done = 1'b0;
    logic [15:0] prev_addr = '0;
    logic prev_last = 1'b0;

    build_model(map, tail);
    exp_cnt   = exp_addr.size();
    exp_nfree = exp_free.size();

    @(negedge clk);
    check({name, " req_ready"}, bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_grp      = grp;
    bus.req_map      = map;
    bus.req_tail_cnt = tail;
    @(posedge clk);

    for (int cyc = 1; cyc <= 20000 && !seen_done; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
`ifdef IBD_ABORT_EN
      bus.abort = 1'b0;
`endif
      bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

      if (bus.rd_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          check($sformatf("%s stall addr", name), bus.rd_addr, prev_addr);
          check($sformatf("%s stall last", name), bus.rd_last, prev_last);
        end
`ifdef IBD_ABORT_EN
        if (abort_addr >= 0 && !aborted && bus.rd_addr == 16'(abort_addr)) begin
          bus.abort = 1'b1;
          aborted   = 1'b1;
          exp_cnt   = n_addr + (bus.rd_ready ? 1 : 0);
          exp_nfree = 0;
          foreach (exp_free_end[k]) if (exp_free_end[k] <= exp_cnt) exp_nfree++;
        end
`endif
        if (bus.rd_ready) begin
          if (n_addr < exp_cnt) begin
            check($sformatf("%s addr[%0d]", name, n_addr), bus.rd_addr, exp_addr[n_addr]);
            check($sformatf("%s last[%0d]", name, n_addr), bus.rd_last, exp_last[n_addr]);
          end else begin
            fail_now($sformatf("%s extra read addr %0h", name, bus.rd_addr));
          end
          n_addr++;
        end
        stalled   = !bus.rd_ready;
        prev_addr = bus.rd_addr;
        prev_last = bus.rd_last;
      end else begin
        stalled = 1'b0;
      end

      if (bus.free_valid) begin
        if (n_free < exp_nfree)
          check($sformatf("%s free[%0d]", name, n_free), bus.free_blk, exp_free[n_free]);
        else
          fail_now($sformatf("%s extra free blk %0h", name, bus.free_blk));
        n_free++;
      end

      if (bus.done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        check({name, " done_grp"}, bus.done_grp, grp);
        check({name, " read count"}, n_addr, exp_cnt);
        check({name, " free count"}, n_free, exp_nfree);
        if (exp_nfree > 0 && !aborted)
          check({name, " final free with done"}, bus.free_valid, 1);
`ifdef IBD_ABORT_EN
        check({name, " done_abort"}, bus.done_abort, aborted);
`endif
      end
    end

    if (!seen_done) begin
      fail_now({name, " timeout waiting for done"});
    end else begin
      if (map == '0) check({name, " empty done latency"}, done_cyc, 2);
      else           check({name, " first rd_valid latency"}, first_valid, 2);
    end
    if (abort_addr >= 0) check({name, " abort taken"}, aborted, 1);

    @(negedge clk);
    check({name, " done pulse ends"}, bus.done, 0);
    check({name, " free pulse ends"}, bus.free_valid, 0);
    check({name, " back in idle"}, bus.req_ready, 1);
  endtask

  initial begin
    logic [255:0] m;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_grp      = '0;
    bus.req_map      = '0;
    bus.req_tail_cnt = '0;
    bus.rd_ready     = 1'b0;
`ifdef IBD_ABORT_EN
    bus.abort        = 1'b0;
`endif

    // Power-on reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rd_valid", bus.rd_valid, 0);
    check("reset free_valid", bus.free_valid, 0);
    check("reset done", bus.done, 0);
    check("reset rd_addr", bus.rd_addr, 0);
    check("reset free_blk", bus.free_blk, 0);
    check("reset done_grp", bus.done_grp, 0);
    rst = 1'b0;

    // T1: reset asserted mid-EMIT abandons the drain.
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_grp = 8'h3C; bus.req_map = m; bus.req_tail_cnt = 8'd0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    repeat (20) @(negedge clk);
    check("T1 emitting before reset", bus.rd_valid, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("T1 rst rd_valid[%0d]", i), bus.rd_valid, 0);
      check($sformatf("T1 rst free_valid[%0d]", i), bus.free_valid, 0);
      check($sformatf("T1 rst done[%0d]", i), bus.done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("T1 req_ready after release", bus.req_ready, 1);
    check("T1 no rd_valid after release", bus.rd_valid, 0);

    // T2: single block, partial tail.
    m = '0; m[5] = 1'b1;
    drain("T2", 8'hA5, m, 8'd3, 1'b0, -1);

    // T3: two full blocks.
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    drain("T3", 8'h17, m, 8'd0, 1'b0, -1);

    // T4: empty map.
    drain("T4", 8'h42, '0, 8'($urandom_range(0, 255)), 1'b0, -1);

    // T5: T3 under random backpressure.
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    drain("T5", 8'h99, m, 8'd0, 1'b1, -1);

    // Random ownership maps, tails and backpressure.
    for (int r = 0; r < 3; r++) begin
      m = '0;
      for (int k = 0; k < 3; k++) m[$urandom_range(0, NB - 1)] = 1'b1;
      drain($sformatf("RND%0d", r), 8'($urandom), m, 8'($urandom_range(0, 255)),
            1'b1, -1);
    end

    // Highest block and lowest block as owners, tail of one entry.
    m = '0; m[0] = 1'b1; m[255] = 1'b1;
    drain("EDGE", 8'hFF, m, 8'd1, 1'b0, -1);

`ifdef IBD_ABORT_EN
    // T6: abort while 0x0210 is presented.
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    drain("T6", 8'h66, m, 8'd0, 1'b1, 16'h0210);
    // Abort on the final entry of the first block: that block is still freed
    // when the entry is accepted.
    drain("T6b", 8'h67, m, 8'd0, 1'b0, 16'h02FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
